// File: rtl/generador_de_secuencia.sv
// Purpose : serial pattern transmitter. It loads a parallel word and shifts it out MSB-first, one bit per clock.
// Latency : the first bit appears on the edge that accepts the load. done follows one cycle after the final bit.
// Backpres: a load is taken only while ready=1. A load while busy is dropped. abort cancels the transfer on the next edge.
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   load               start request (accepted when ready=1 and abort=0)
//   data_in            pattern; only the low L bits are sent
//   len_in             pattern length; 0 or >PATTERN_WIDTH selects PATTERN_WIDTH
//   rep_in             extra repetitions (rep_in+1 transmissions in total)
//   abort              synchronous cancel of the running transfer
//   ready              idle, a load will be accepted
//   w, w_valid         serial bit and its qualifier
//   busy               transfer in progress (SHIFT or GAP)
//   done               single-cycle completion pulse
module generador_de_secuencia #(
  parameter int PATTERN_WIDTH = 8,
  parameter int LEN_W         = 4,
  parameter int REP_W         = 4,
  parameter int GAP           = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [PATTERN_WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0]         len_in,
  input  logic [REP_W-1:0]         rep_in,
  input  logic                     abort,
  output logic                     ready,
  output logic                     w,
  output logic                     w_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] PW_L = LEN_W'(PATTERN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP_S = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  // Pattern left-aligned so that bit L-1 sits at the MSB. This copy is kept for repetitions.
  logic [PATTERN_WIDTH-1:0] data_q, data_d;
  // Working shift register. Its MSB is the next bit to send.
  logic [PATTERN_WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]         len_q, len_d;
  // Number of bits still to send after the bit currently on w.
  logic [LEN_W-1:0]         bitcnt_q, bitcnt_d;
  // Number of repetitions still to send after the current one.
  logic [REP_W-1:0]         repcnt_q, repcnt_d;
  logic [GAP_W-1:0]         gapcnt_q, gapcnt_d;
  logic                     w_q, w_d;
  logic                     w_valid_q, w_valid_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Length clamp and MSB alignment of the incoming pattern.
  logic [LEN_W-1:0]         l_eff;
  logic [LEN_W-1:0]         shamt;
  logic [PATTERN_WIDTH-1:0] aligned;

  always_comb begin
    l_eff   = ((len_in == '0) || (len_in > PW_L)) ? PW_L : len_in;
    shamt   = PW_L - l_eff;
    aligned = data_in << shamt;
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    bitcnt_d  = bitcnt_q;
    repcnt_d  = repcnt_q;
    gapcnt_d  = gapcnt_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous load.
        if (load && !abort) begin
          data_d    = aligned;
          len_d     = l_eff;
          repcnt_d  = rep_in;
          w_d       = aligned[PATTERN_WIDTH-1];
          w_valid_d = 1'b1;
          shreg_d   = aligned << 1;
          bitcnt_d  = l_eff - LEN_W'(1);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bitcnt_q != '0) begin
          w_d       = shreg_q[PATTERN_WIDTH-1];
          w_valid_d = 1'b1;
          shreg_d   = shreg_q << 1;
          bitcnt_d  = bitcnt_q - LEN_W'(1);
        end else if (repcnt_q != '0) begin
          repcnt_d = repcnt_q - REP_W'(1);
          if (GAP == 0) begin
            // Start the next repetition with no idle cycle in between.
            w_d       = data_q[PATTERN_WIDTH-1];
            w_valid_d = 1'b1;
            shreg_d   = data_q << 1;
            bitcnt_d  = len_q - LEN_W'(1);
          end else begin
            // This edge starts the first idle cycle, so GAP-1 more remain.
            gapcnt_d = GAP_W'(GAP - 1);
            state_d  = GAP_S;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      GAP_S: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gapcnt_q == '0) begin
          w_d       = data_q[PATTERN_WIDTH-1];
          w_valid_d = 1'b1;
          shreg_d   = data_q << 1;
          bitcnt_d  = len_q - LEN_W'(1);
          state_d   = SHIFT;
        end else begin
          gapcnt_d = gapcnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // ready and busy are registered copies of the next state's class.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      shreg_q   <= '0;
      len_q     <= '0;
      bitcnt_q  <= '0;
      repcnt_q  <= '0;
      gapcnt_q  <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shreg_q   <= shreg_d;
      len_q     <= len_d;
      bitcnt_q  <= bitcnt_d;
      repcnt_q  <= repcnt_d;
      gapcnt_q  <= gapcnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
